wishbone_master_if: RTL and testbench
=====================================

WISHBONE_MASTER_IF -- requirements
Module: wishbone_master_if

Interface
REQ-001 Parameter DW, default 32: data bus width in bits; multiple of 8, minimum 8.
REQ-002 Parameter AW, default 32: address bus width in bits.
REQ-003 Parameter SW, default DW/8: byte-select width.
REQ-004 Parameter TIMEOUT, default 255: maximum BUSY cycles without ack/err; valid range 2..65535.
REQ-005 The block SHALL have one clock and a synchronous, active-low reset.
REQ-006 Port clk, input, 1: rising-edge clock.
REQ-007 Port rst, input, 1: synchronous reset, active low.
REQ-008 Port stall_i, input, 6: pipeline stall vector from ctrl.
REQ-009 Port flush_i, input, 1: pipeline flush.
REQ-010 Port cpu_ce_i, input, 1: CPU access request.
REQ-011 Port cpu_data_i, input, DW: CPU write data.
REQ-012 Port cpu_addr_i, input, AW: CPU address.
REQ-013 Port cpu_we_i, input, 1: 1 = write, 0 = read.
REQ-014 Port cpu_sel_i, input, SW: byte enables.
REQ-015 Port cpu_data_o, output, DW: read data to CPU.
REQ-016 Port cpu_err_o, output, 1: access ended in bus error or timeout.
REQ-017 Port stallreq, output, 1: pipeline stall request.
REQ-018 Wishbone ports: wishbone_data_i (in, DW), wishbone_ack_i (in, 1), wishbone_err_i (in, 1), wishbone_addr_o (out, AW), wishbone_data_o (out, DW), wishbone_we_o (out, 1), wishbone_sel_o (out, SW), wishbone_stb_o (out, 1), wishbone_cyc_o (out, 1).

Function
REQ-019 FSM states SHALL be IDLE, BUSY and WAIT_FOR_STALL; all bus outputs are registered; stallreq, cpu_data_o and cpu_err_o are combinational from state and inputs.
REQ-020 IDLE: when cpu_ce_i=1 and flush_i=0, the block SHALL assert stallreq in the same cycle, register addr/data/we/sel, set stb=cyc=1 on the next edge and enter BUSY; otherwise it stays in IDLE with stallreq=0.
REQ-021 BUSY: stallreq=1 while neither ack nor err is seen.
REQ-022 BUSY with ack=1: stallreq=0 that cycle; cpu_data_o = wishbone_data_i on a read, 0 on a write; rd_buf captures the same value; next edge clears stb/cyc/addr/data/we/sel and enters WAIT_FOR_STALL, for both reads and writes.
REQ-023 BUSY with err=1 and ack=0: stallreq=0; cpu_data_o=0; cpu_err_o=1; err_buf<=1; rd_buf<=0; bus signals cleared; enter WAIT_FOR_STALL.
REQ-024 When ack and err are asserted together, ack SHALL take priority.
REQ-025 BUSY with flush_i=1 and neither ack nor err: the block SHALL abort, clear bus signals, rd_buf and err_buf, and enter IDLE; stallreq=0 that cycle.
REQ-026 WAIT_FOR_STALL: stallreq=0, cpu_data_o=rd_buf, cpu_err_o=err_buf; the block returns to IDLE when stall_i=6'b000000 or flush_i=1, and clears err_buf on exit.
REQ-027 In IDLE, cpu_data_o=0 and cpu_err_o=0.
REQ-028 The block SHALL start no new request in WAIT_FOR_STALL; cpu_ce_i is ignored until IDLE.

Reset
REQ-029 With rst=0 at a clock edge, the block SHALL enter IDLE and clear all wishbone_* outputs, rd_buf, err_buf and the timeout counter; this applies from any state, including mid-transfer.
REQ-030 While rst=0, stallreq, cpu_data_o and cpu_err_o SHALL be 0.

Configuration
REQ-031 Macro WB_TIMEOUT_EN defined: a 16-bit counter clears on entry to BUSY and increments each BUSY cycle; when it reaches TIMEOUT-1 with no ack/err, the block SHALL behave exactly as for err (REQ-023).
REQ-032 WB_TIMEOUT_EN undefined: no counter is built, and BUSY waits indefinitely for ack, err or flush.

Verification
REQ-033 Read: addr=0x100, slave ack after 3 cycles with data 0xDEADBEEF -> stallreq=1 for 4 cycles; cpu_data_o=0xDEADBEEF on the ack cycle and while stall_i!=0; state returns to IDLE when stall_i=0.
REQ-034 Write: data=0x12345678, sel=4'b0011 -> bus outputs show these values during BUSY; ack -> cpu_data_o=0; WAIT_FOR_STALL entered.
REQ-035 Error: err=1 in the 2nd BUSY cycle -> cpu_err_o=1, cpu_data_o=0, stb/cyc=0 next cycle; cpu_err_o stays 1 until stall_i=0.
REQ-036 Flush: flush_i=1 in BUSY with ack=0 -> stb/cyc=0 next edge, state IDLE, stallreq=0.
REQ-037 Timeout (WB_TIMEOUT_EN, TIMEOUT=4), no ack -> cpu_err_o=1 in the 4th BUSY cycle; stb drops the next cycle.
REQ-038 rst=0 in BUSY -> all outputs 0 at the next edge; a request 1 cycle after rst=1 completes normally.

Source files
------------

// File: rtl/wishbone_master_if.sv
// Single-transfer Wishbone master bridging a stalling CPU pipeline to the bus.
// Optional BUSY timeout counter enabled by defining WB_TIMEOUT_EN.
module wishbone_master_if #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int SW      = DW / 8,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [5:0]    stall_i,
    input  logic          flush_i,
    input  logic          cpu_ce_i,
    input  logic [DW-1:0] cpu_data_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic          cpu_we_i,
    input  logic [SW-1:0] cpu_sel_i,
    output logic [DW-1:0] cpu_data_o,
    output logic          cpu_err_o,
    output logic          stallreq,
    input  logic [DW-1:0] wishbone_data_i,
    input  logic          wishbone_ack_i,
    input  logic          wishbone_err_i,
    output logic [AW-1:0] wishbone_addr_o,
    output logic [DW-1:0] wishbone_data_o,
    output logic          wishbone_we_o,
    output logic [SW-1:0] wishbone_sel_o,
    output logic          wishbone_stb_o,
    output logic          wishbone_cyc_o
);

    typedef enum logic [1:0] {IDLE, BUSY, WAIT_FOR_STALL} state_t;

    state_t        state;
    logic [DW-1:0] rd_buf;
    logic          err_buf;
    logic          timeout_hit;
    logic          bus_err;
    logic [DW-1:0] ack_data;

`ifdef WB_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    assign timeout_hit = (tmo_cnt == 16'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Ack wins over err; a timeout is treated as an err.
    assign bus_err  = !wishbone_ack_i && (wishbone_err_i || timeout_hit);
    assign ack_data = wishbone_we_o ? '0 : wishbone_data_i;

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        stallreq   = 1'b0;
        cpu_data_o = '0;
        cpu_err_o  = 1'b0;
        if (rst) begin
            unique case (state)
                IDLE: stallreq = cpu_ce_i && !flush_i;
                BUSY: begin
                    if (wishbone_ack_i) begin
                        cpu_data_o = ack_data;
                    end else if (bus_err) begin
                        cpu_err_o = 1'b1;
                    end else begin
                        stallreq = !flush_i;
                    end
                end
                WAIT_FOR_STALL: begin
                    cpu_data_o = rd_buf;
                    cpu_err_o  = err_buf;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            rd_buf          <= '0;
            err_buf         <= 1'b0;
            wishbone_addr_o <= '0;
            wishbone_data_o <= '0;
            wishbone_we_o   <= 1'b0;
            wishbone_sel_o  <= '0;
            wishbone_stb_o  <= 1'b0;
            wishbone_cyc_o  <= 1'b0;
`ifdef WB_TIMEOUT_EN
            tmo_cnt         <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu_ce_i && !flush_i) begin
                        wishbone_addr_o <= cpu_addr_i;
                        wishbone_data_o <= cpu_data_i;
                        wishbone_we_o   <= cpu_we_i;
                        wishbone_sel_o  <= cpu_sel_i;
                        wishbone_stb_o  <= 1'b1;
                        wishbone_cyc_o  <= 1'b1;
                        state           <= BUSY;
`ifdef WB_TIMEOUT_EN
                        tmo_cnt         <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (wishbone_ack_i || bus_err || flush_i) begin
                        wishbone_addr_o <= '0;
                        wishbone_data_o <= '0;
                        wishbone_we_o   <= 1'b0;
                        wishbone_sel_o  <= '0;
                        wishbone_stb_o  <= 1'b0;
                        wishbone_cyc_o  <= 1'b0;
                    end
                    if (wishbone_ack_i) begin
                        rd_buf <= ack_data;
                        state  <= WAIT_FOR_STALL;
                    end else if (bus_err) begin
                        rd_buf  <= '0;
                        err_buf <= 1'b1;
                        state   <= WAIT_FOR_STALL;
                    end else if (flush_i) begin
                        rd_buf  <= '0;
                        err_buf <= 1'b0;
                        state   <= IDLE;
                    end else begin
`ifdef WB_TIMEOUT_EN
                        tmo_cnt <= tmo_cnt + 16'd1;
`endif
                    end
                end
                WAIT_FOR_STALL: begin
                    if (stall_i == 6'b000000 || flush_i) begin
                        err_buf <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_master_if.sv
// Directed, table-driven bench for wishbone_master_if (DW=AW=32, TIMEOUT=4).
// The timeout sequence follows the WB_TIMEOUT_EN build of the design.
module tb_wishbone_master_if;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i, cpu_ce_i, cpu_we_i;
    logic [31:0] cpu_data_i, cpu_addr_i, cpu_data_o, wishbone_data_i;
    logic [3:0]  cpu_sel_i, wishbone_sel_o;
    logic        cpu_err_o, stallreq, wishbone_ack_i, wishbone_err_i;
    logic [31:0] wishbone_addr_o, wishbone_data_o;
    logic        wishbone_we_o, wishbone_stb_o, wishbone_cyc_o;

    wishbone_master_if #(.DW(32), .AW(32), .SW(4), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .cpu_ce_i(cpu_ce_i), .cpu_data_i(cpu_data_i), .cpu_addr_i(cpu_addr_i),
        .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
        .cpu_err_o(cpu_err_o), .stallreq(stallreq),
        .wishbone_data_i(wishbone_data_i), .wishbone_ack_i(wishbone_ack_i),
        .wishbone_err_i(wishbone_err_i), .wishbone_addr_o(wishbone_addr_o),
        .wishbone_data_o(wishbone_data_o), .wishbone_we_o(wishbone_we_o),
        .wishbone_sel_o(wishbone_sel_o), .wishbone_stb_o(wishbone_stb_o),
        .wishbone_cyc_o(wishbone_cyc_o)
    );

    always #5 clk = ~clk;

    // One record per clock cycle: inputs driven that cycle, outputs expected
    // before the following rising edge (x_cyc covers both stb and cyc).
    typedef struct {
        logic        rst, ce, we, flush, ack, err;
        logic [5:0]  stall;
        logic [31:0] addr, wdata;
        logic [3:0]  sel;
        logic [31:0] rdata;
        logic        x_stall;
        logic [31:0] x_data;
        logic        x_err, x_cyc, x_we;
        logic [31:0] x_addr, x_wdata;
        logic [3:0]  x_sel;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [104:0] act, input logic [104:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string name);
        @(negedge clk);
        rst = v.rst; cpu_ce_i = v.ce; cpu_we_i = v.we; flush_i = v.flush;
        wishbone_ack_i = v.ack; wishbone_err_i = v.err; stall_i = v.stall;
        cpu_addr_i = v.addr; cpu_data_i = v.wdata; cpu_sel_i = v.sel;
        wishbone_data_i = v.rdata;
        #1;
        check(name,
              {stallreq, cpu_data_o, cpu_err_o, wishbone_stb_o, wishbone_cyc_o,
               wishbone_we_o, wishbone_addr_o, wishbone_data_o, wishbone_sel_o},
              {v.x_stall, v.x_data, v.x_err, v.x_cyc, v.x_cyc,
               v.x_we, v.x_addr, v.x_wdata, v.x_sel});
    endtask

    initial begin
        rst = 1'b0; stall_i = '0; flush_i = 1'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
        cpu_data_i = '0; cpu_addr_i = '0; cpu_sel_i = '0; wishbone_data_i = '0;
        wishbone_ack_i = 1'b0; wishbone_err_i = 1'b0;
        repeat (2) @(posedge clk);

        // reset state
        tbl.push_back('{0,0,0,0,0,0,6'h00,0,0,0,0, 0,0,0,0,0,0,0,0});
        // read 0x100, ack in 4th BUSY cycle, held in WAIT_FOR_STALL
        tbl.push_back('{1,1,0,0,0,0,6'h00,'h100,0,'hF,0, 1,0,0,0,0,0,0,0});
        tbl.push_back('{1,0,0,0,0,0,6'h00,'h100,0,'hF,0, 1,0,0,1,0,'h100,0,'hF});
        tbl.push_back('{1,0,0,0,0,0,6'h00,'h100,0,'hF,0, 1,0,0,1,0,'h100,0,'hF});
        tbl.push_back('{1,0,0,0,0,0,6'h00,'h100,0,'hF,0, 1,0,0,1,0,'h100,0,'hF});
        tbl.push_back('{1,0,0,0,1,0,6'h01,'h100,0,'hF,'hDEADBEEF, 0,'hDEADBEEF,0,1,0,'h100,0,'hF});
        tbl.push_back('{1,0,0,0,0,0,6'h01,'h100,0,'hF,0, 0,'hDEADBEEF,0,0,0,0,0,0});
        tbl.push_back('{1,1,0,0,0,0,6'h01,'h100,0,'hF,0, 0,'hDEADBEEF,0,0,0,0,0,0});
        tbl.push_back('{1,0,0,0,0,0,6'h00,0,0,0,0, 0,'hDEADBEEF,0,0,0,0,0,0});
        tbl.push_back('{1,0,0,0,0,0,6'h00,0,0,0,0, 0,0,0,0,0,0,0,0});
        // write 0x12345678 sel 0011
        tbl.push_back('{1,1,1,0,0,0,6'h00,'h200,'h12345678,'h3,0, 1,0,0,0,0,0,0,0});
        tbl.push_back('{1,0,1,0,0,0,6'h00,'h200,'h12345678,'h3,0, 1,0,0,1,1,'h200,'h12345678,'h3});
        tbl.push_back('{1,0,1,0,1,0,6'h00,'h200,'h12345678,'h3,'hFFFFFFFF, 0,0,0,1,1,'h200,'h12345678,'h3});
        tbl.push_back('{1,0,0,0,0,0,6'h00,0,0,0,'hFFFFFFFF, 0,0,0,0,0,0,0,0});
        // bus error in 2nd BUSY cycle
        tbl.push_back('{1,1,0,0,0,0,6'h00,'h300,0,'hF,0, 1,0,0,0,0,0,0,0});
        tbl.push_back('{1,0,0,0,0,0,6'h00,'h300,0,'hF,0, 1,0,0,1,0,'h300,0,'hF});
        tbl.push_back('{1,0,0,0,0,1,6'h02,'h300,0,'hF,'hAAAA5555, 0,0,1,1,0,'h300,0,'hF});
        tbl.push_back('{1,0,0,0,0,0,6'h02,0,0,0,0, 0,0,1,0,0,0,0,0});
        tbl.push_back('{1,0,0,0,0,0,6'h00,0,0,0,0, 0,0,1,0,0,0,0,0});
        tbl.push_back('{1,0,0,0,0,0,6'h00,0,0,0,0, 0,0,0,0,0,0,0,0});
        // ack and err together: ack wins; WAIT left via flush; flush blocks IDLE request
        tbl.push_back('{1,1,0,0,0,0,6'h00,'h400,0,'hF,0, 1,0,0,0,0,0,0,0});
        tbl.push_back('{1,0,0,0,1,1,6'h01,'h400,0,'hF,'hCAFEF00D, 0,'hCAFEF00D,0,1,0,'h400,0,'hF});
        tbl.push_back('{1,0,0,0,0,0,6'h01,0,0,0,0, 0,'hCAFEF00D,0,0,0,0,0,0});
        tbl.push_back('{1,0,0,1,0,0,6'h01,0,0,0,0, 0,'hCAFEF00D,0,0,0,0,0,0});
        tbl.push_back('{1,1,0,1,0,0,6'h01,'h450,0,'hF,0, 0,0,0,0,0,0,0,0});
        tbl.push_back('{1,0,0,0,0,0,6'h00,0,0,0,0, 0,0,0,0,0,0,0,0});
        // flush during BUSY
        tbl.push_back('{1,1,0,0,0,0,6'h00,'h500,0,'hF,0, 1,0,0,0,0,0,0,0});
        tbl.push_back('{1,0,0,0,0,0,6'h00,'h500,0,'hF,0, 1,0,0,1,0,'h500,0,'hF});
        tbl.push_back('{1,0,0,1,0,0,6'h00,'h500,0,'hF,0, 0,0,0,1,0,'h500,0,'hF});
        tbl.push_back('{1,0,0,0,0,0,6'h00,0,0,0,0, 0,0,0,0,0,0,0,0});
        // reset mid-transfer, then a normal read
        tbl.push_back('{1,1,1,0,0,0,6'h00,'h600,'h55AA55AA,'hC,0, 1,0,0,0,0,0,0,0});
        tbl.push_back('{0,1,1,0,0,0,6'h00,'h600,'h55AA55AA,'hC,0, 0,0,0,1,1,'h600,'h55AA55AA,'hC});
        tbl.push_back('{1,0,0,0,0,0,6'h00,0,0,0,0, 0,0,0,0,0,0,0,0});
        tbl.push_back('{1,1,0,0,0,0,6'h00,'h700,0,'hF,0, 1,0,0,0,0,0,0,0});
        tbl.push_back('{1,0,0,0,1,0,6'h00,'h700,0,'hF,'h01234567, 0,'h01234567,0,1,0,'h700,0,'hF});
        tbl.push_back('{1,0,0,0,0,0,6'h00,0,0,0,0, 0,'h01234567,0,0,0,0,0,0});
        tbl.push_back('{1,0,0,0,0,0,6'h00,0,0,0,0, 0,0,0,0,0,0,0,0});

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // long BUSY: timeout build errors out in the 4th cycle, default build keeps waiting
        step('{1,1,0,0,0,0,6'h00,'h800,0,'hF,0, 1,0,0,0,0,0,0,0}, "tmo_req");
`ifdef WB_TIMEOUT_EN
        for (int i = 1; i <= 3; i++)
            step('{1,0,0,0,0,0,6'h01,'h800,0,'hF,0, 1,0,0,1,0,'h800,0,'hF}, $sformatf("tmo_busy%0d", i));
        step('{1,0,0,0,0,0,6'h01,'h800,0,'hF,'h11111111, 0,0,1,1,0,'h800,0,'hF}, "tmo_fire");
        step('{1,0,0,0,0,0,6'h01,0,0,0,0, 0,0,1,0,0,0,0,0}, "tmo_wait");
        step('{1,0,0,0,0,0,6'h00,0,0,0,0, 0,0,1,0,0,0,0,0}, "tmo_exit");
`else
        for (int i = 1; i <= 8; i++)
            step('{1,0,0,0,0,0,6'h01,'h800,0,'hF,0, 1,0,0,1,0,'h800,0,'hF}, $sformatf("hold_busy%0d", i));
        step('{1,0,0,0,1,0,6'h00,'h800,0,'hF,'h0BADF00D, 0,'h0BADF00D,0,1,0,'h800,0,'hF}, "hold_ack");
        step('{1,0,0,0,0,0,6'h00,0,0,0,0, 0,'h0BADF00D,0,0,0,0,0,0}, "hold_wait");
`endif
        step('{1,0,0,0,0,0,6'h00,0,0,0,0, 0,0,0,0,0,0,0,0}, "final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
